mio_responder: RTL
==================

Name: mio_responder

Overview:
- Memory/IO responder on the far side of the multi-cycle CPU's MemRead/MemWrite/mio_ready handshake.
- Accepts one word access at a time, then services it from one of two targets:
  - an external synchronous block RAM, with programmable wait states;
  - a small memory-mapped IO register file (LEDs, switches, cycle counter).
- Returns a one-cycle mio_ready pulse together with registered read data.
- Sits between the CPU datapath/controller and the board-level RAM and IO pins.

Parameters:
- WAIT_CYCLES, 2, cycles a RAM access spends in RAM_WAIT; legal range 1..15.
- RAM_AW, 10, RAM word-address width. RAM index is addr[RAM_AW+1:2].
- IO_TAG, 4'hF, value of addr[31:28] that selects the IO region.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_read  in  1  CPU read request; held until mio_ready is seen.
- mem_write  in  1  CPU write request; held until mio_ready is seen.
- addr  in  32  byte address; addr[1:0] ignored (word access only).
- wdata  in  32  CPU write data.
- rdata  out  32  registered read data.
- mio_ready  out  1  one-cycle completion pulse.
- err  out  1  sticky protocol-error flag.
- ram_addr  out  RAM_AW  RAM word address.
- ram_we  out  1  RAM write enable.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid 1 cycle after ram_addr.
- sw  in  16  asynchronous switch inputs.
- led  out  16  LED register.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; mio_ready=0, ram_we=0, rdata=0, err=0, led=0.
  - Cycle counter=0; both switch sync flops=0.
  - Any access in flight is dropped without a mio_ready pulse.
- States: IDLE, RAM_WAIT, IO_ACC, DONE.
- IDLE:
  - If mem_read|mem_write, capture addr, wdata and rw into internal registers (accept cycle).
  - IO region: addr[31:28]==IO_TAG -> next state IO_ACC.
  - Otherwise -> RAM_WAIT with wait counter loaded to WAIT_CYCLES-1.
  - No request: stay in IDLE.
- RAM interface:
  - ram_addr is driven from the captured address from the cycle after accept until DONE.
  - On a write, ram_we=1 for exactly the first RAM_WAIT cycle, with ram_din=captured wdata.
  - Otherwise ram_we=0.
- RAM_WAIT:
  - Decrement the counter each cycle; at 0 -> DONE.
  - On a read, rdata<=ram_dout on the transition into DONE.
- IO_ACC: one cycle, then DONE. Offset is addr[3:2]:
  - 0 = led, read/write. Write takes wdata[15:0]; read returns {16'b0, led}.
  - 1 = switches, read-only. Returns {16'b0, sw_sync}; writes ignored.
  - 2 = cycle counter, 32-bit free-running, wraps 32'hFFFFFFFF->0. A write clears it to 0; that write wins over the increment.
  - 3 = reserved. Reads return 0; writes ignored.
- DONE:
  - mio_ready=1 for exactly this cycle; next state IDLE unconditionally.
  - A request seen in the following IDLE cycle is a new access, which is how MEM_W->IF back-to-back requests work.
- Latency, measured from the accept cycle N:
  - RAM access: mio_ready high in cycle N+WAIT_CYCLES+1.
  - IO access: mio_ready high in cycle N+2.
- rdata is updated only on read completion and held otherwise, including across writes.
- Protocol errors:
  - mem_read and mem_write both high at accept: perform the write only, and set err.
  - Request dropped before mio_ready: set err; the access still completes and pulses mio_ready.
  - err is cleared only by reset.
- Request inputs are ignored outside IDLE, apart from the drop check.
- Switch inputs pass through a 2-flop synchronizer, so a sw change is visible on reads 2 cycles later.
- RAM addresses above the RAM size alias modulo 2^RAM_AW words.

Test Plan:
- Reset then RAM read, WAIT_CYCLES=2: preload RAM word 5=32'hDEADBEEF, mem_read at addr 32'h14 in cycle 0 -> mio_ready only in cycle 3, rdata=32'hDEADBEEF, err=0.
- RAM write then immediate read (MEM_W->IF pattern): write 32'h12345678 to addr 32'h20 -> single ram_we pulse with ram_addr=8. Next cycle, read the same address -> rdata=32'h12345678, and no spurious second write.
- LED write then switch read:
  - Write 32'hABCD_1234 to 32'hF000_0000 -> led=16'h1234, mio_ready 2 cycles after accept.
  - With sw=16'h00F0 held, read 32'hF000_0004 -> rdata=32'h000000F0.
- Counter:
  - Write to 32'hF000_0008 clears the count.
  - A read issued 10 cycles later returns the cycle distance from the clear to the read-accept capture.
  - Force the count to 32'hFFFFFFFF -> it wraps to 0.
- Errors and reset:
  - mem_read=mem_write=1 -> write performed, rdata unchanged, err=1.
  - reset=0 during RAM_WAIT -> no mio_ready pulse, all outputs return to reset values, and the next access completes normally.

Source files
------------

// File: rtl/mio_responder_if.sv
// CPU-side memory/IO handshake: request held until a one-cycle mio_ready completion.
interface mio_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mio_ready;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, mio_ready, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, mio_ready, err
    );
endinterface

// File: rtl/mio_responder.sv
// Memory/IO responder: serves one CPU word access from block RAM (wait states) or the IO register file.
// Latency: RAM WAIT_CYCLES+1 cycles, IO 2 cycles after accept; requests outside IDLE only feed the drop check.
module mio_responder #(
    parameter int          WAIT_CYCLES = 2,
    parameter int          RAM_AW      = 10,
    parameter logic [3:0]  IO_TAG      = 4'hF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    mio_responder_if.slave    bus,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [31:0]       o_ram_din,
    input  logic [31:0]       i_ram_dout,
    input  logic [15:0]       i_sw,
    output logic [15:0]       o_led
);
    typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_ACC, DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wr;
    logic [3:0]  r_wcnt;
    logic [31:0] r_rdata;
    logic        r_ready;
    logic        r_err;
    logic        r_ram_we;
    logic [15:0] r_led;
    logic [31:0] r_cnt;
    logic [31:0] r_cnt_snap;
    logic [15:0] r_sw_s1;
    logic [15:0] r_sw_s2;

    logic        w_req;
    logic [1:0]  w_off;
    logic        w_cnt_clr;
    logic [31:0] w_io_rdata;
    logic        w_unused;

    assign w_req     = bus.mem_read | bus.mem_write;
    assign w_off     = r_addr[3:2];
    assign w_cnt_clr = (r_state == IO_ACC) && r_wr && (w_off == 2'd2);
    assign w_unused  = &{1'b0, r_addr[31:RAM_AW+2], r_addr[1:0]};

    always_comb begin
        w_io_rdata = 32'h0;
        case (w_off)
            2'd0:    w_io_rdata = {16'h0, r_led};
            2'd1:    w_io_rdata = {16'h0, r_sw_s2};
            2'd2:    w_io_rdata = r_cnt_snap;
            default: w_io_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_wcnt     <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_ram_we   <= 1'b0;
            r_led      <= '0;
            r_cnt_snap <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    if (w_req) begin
                        r_addr     <= bus.addr;
                        r_wdata    <= bus.wdata;
                        r_wr       <= bus.mem_write;
                        r_cnt_snap <= r_cnt;
                        // read+write together: the write wins and the clash is flagged
                        if (bus.mem_read && bus.mem_write)
                            r_err <= 1'b1;
                        if (bus.addr[31:28] == IO_TAG) begin
                            r_state <= IO_ACC;
                        end else begin
                            r_state  <= RAM_WAIT;
                            r_wcnt   <= WAIT_LOAD;
                            r_ram_we <= bus.mem_write;
                        end
                    end
                end
                RAM_WAIT: begin
                    r_ram_we <= 1'b0;
                    if (!w_req)
                        r_err <= 1'b1;
                    if (r_wcnt == 4'd0) begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                        if (!r_wr)
                            r_rdata <= i_ram_dout;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                IO_ACC: begin
                    if (!w_req)
                        r_err <= 1'b1;
                    r_state <= DONE;
                    r_ready <= 1'b1;
                    if (r_wr) begin
                        if (w_off == 2'd0)
                            r_led <= r_wdata[15:0];
                    end else begin
                        r_rdata <= w_io_rdata;
                    end
                end
                DONE: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Free-running cycle counter; a write to its offset clears it and beats the increment.
    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_cnt <= '0;
        else if (w_cnt_clr)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= i_sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.mio_ready = r_ready;
    assign bus.err       = r_err;
    assign o_ram_addr    = r_addr[RAM_AW+1:2];
    assign o_ram_we      = r_ram_we;
    assign o_ram_din     = r_wdata;
    assign o_led         = r_led;
endmodule
